sprite_anim_indexer: RTL and testbench
======================================

# sprite_anim_indexer

- Upstream fetch stage for the sprite palette lookup.
- Takes the VGA scan position and a sprite's screen position, and runs the attack-animation frame sequence.
- Computes the sprite ROM address and registers the 4-bit palette index (plus an opaque flag) that drives the palette LUT.
- One instance per animated move; it sits between the VGA controller and the move's index ROM / palette pair.

## Interface
Parameters:
- SPR_W, 64: sprite width in pixels.
- SPR_H, 96: sprite height in pixels.
- N_FRAMES, 4: animation frames stored back-to-back in the ROM.
- TICKS_PER_FRAME, 5: frame_tick pulses each animation frame is held.
- ADDR_W, 15: ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H*N_FRAMES.

Ports:
- Clk  in  1  pixel clock. One clock domain; reset is synchronous and active-high.
- Reset  in  1  synchronous active-high reset.
- DrawX  in  10  current scan column.
- DrawY  in  10  current scan row.
- blank  in  1  1 = visible pixel (vga_controller convention).
- frame_tick  in  1  one-cycle pulse per video frame, at vsync.
- start  in  1  one-cycle request to play the animation.
- flip  in  1  1 = mirror horizontally (sprite faces left).
- pos_x  in  10  sprite left edge, sampled on frame_tick.
- pos_y  in  10  sprite top edge, sampled on frame_tick.
- rom_addr  out  ADDR_W  registered address to the synchronous index ROM.
- rom_q  in  4  ROM data, valid one cycle after rom_addr.
- index  out  4  palette index to the palette LUT.
- opaque  out  1  1 = draw this pixel; 0 = background shows through.
- busy  out  1  high while the state machine is in PLAY.
- done  out  1  one-cycle pulse when the animation completes.

## Operation
- FSM has two states, IDLE and PLAY.
  - IDLE: frame = 0, tick_cnt = 0. start moves it to PLAY.
  - PLAY: each frame_tick increments tick_cnt. When tick_cnt reaches TICKS_PER_FRAME-1 on a frame_tick, tick_cnt goes to 0 and frame increments.
  - On the last frame, that same event pulses done and returns to IDLE with frame = 0.
- start while in PLAY is ignored; there is no restart.
- start and frame_tick in the same IDLE cycle: the FSM enters PLAY and that tick is not counted.
- frame, flip, pos_x and pos_y are latched only on frame_tick, so the displayed frame never changes mid-scan.
- In-box test: col = DrawX - pos_x_l and row = DrawY - pos_y_l, as 11-bit signed values. The pixel is in the box when 0 <= col < SPR_W and 0 <= row < SPR_H.
- Horizontal mirror: col_eff = flip_l ? SPR_W-1-col : col.
- Address: rom_addr = frame*SPR_W*SPR_H + row*SPR_W + col_eff, computed at full width and truncated to ADDR_W. When not in the box, rom_addr = 0.
- Output:
  - index = rom_q when in the box and blank = 1; otherwise index = 0.
  - opaque = 1 exactly when index != 0. Index 0 is the magenta transparency key.
- A sprite partly off-screen (pos_x near 639, or pos_x + SPR_W > 640) is clipped naturally by the in-box test; there is no wrap-around.

## Timing
- Fixed 3-cycle pipeline:
  - Edge k: samples DrawX, DrawY and blank, and registers rom_addr plus in-box/blank delay bits.
  - Edge k+1: the ROM presents rom_q.
  - Edge k+2: index and opaque are registered.
- index for pixel (X,Y) is therefore valid 3 cycles after DrawX = X is presented. The top level delays hs/vs to match.
- busy rises the cycle after start is sampled in IDLE, and falls in the same cycle done is high.
- done is high for exactly one cycle.
- Reset values: rom_addr = 0, index = 0, opaque = 0, busy = 0, done = 0, FSM = IDLE, frame = 0, tick_cnt = 0. Latched pos_x, pos_y and flip are all 0.
- Reset mid-PLAY: the next cycle is IDLE with frame 0. There is no done pulse, and the pipeline registers clear.

## Configuration
- SPRITE_ANIM_LOOP_EN:
  - Defined: after the last frame the FSM wraps to frame 0 and stays in PLAY. done pulses on every wrap, busy stays high, and only Reset returns the FSM to IDLE.
  - Undefined: one-shot behaviour as above.

## Test plan
- Idle render: Reset, then pos = (100,200), flip = 0, with a ROM holding rom_q = addr[3:0]. Scan DrawX = 100..163 on DrawY = 200. rom_addr must equal DrawX - 100; index must follow 3 cycles later; opaque = 0 wherever rom_q = 0.
- Out of box / blank: DrawX = 99 or 164, DrawY = 296, or blank = 0 -> index = 0, opaque = 0, rom_addr = 0.
- Flip: flip = 1 latched on frame_tick; DrawX = 100, DrawY = 201 -> rom_addr = 64 + 63 = 127.
- Sequence: start, then 20 frame_ticks. frame must step 0→1→2→3 every 5 ticks. At tick 20, done pulses once and busy falls in the same cycle. A row-0 address in frame 2 = 2*6144 = 12288.
- Edge events:
  - start coincident with frame_tick: PLAY with tick_cnt still 0.
  - start during PLAY: ignored.
  - Reset at tick 7: IDLE, frame 0, no done pulse.
- Loop (SPRITE_ANIM_LOOP_EN defined): 40 ticks after start -> done pulses at ticks 20 and 40, busy stays 1, and frame returns to 0 after each wrap.

Source files
------------

// File: rtl/sprite_anim_indexer.sv
`default_nettype none
// ============================================================================
// Module      : sprite_anim_indexer
// Description : Sprite palette-index fetch stage. Tests the VGA scan position
//               against a sprite box, forms the index-ROM address (with
//               optional horizontal mirror and animation-frame offset) and
//               registers the 4-bit palette index plus an opaque flag.
//               An IDLE/PLAY state machine steps the animation frames on
//               frame_tick. Pipeline: DrawX -> index is 3 clocks.
//               Build option: define SPRITE_ANIM_LOOP_EN for a looping
//               animation; leave it undefined for one-shot playback.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_anim_indexer #(
    parameter int SPR_W           = 64,
    parameter int SPR_H           = 96,
    parameter int N_FRAMES        = 4,
    parameter int TICKS_PER_FRAME = 5,
    parameter int ADDR_W          = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_tick,
    input  logic              start,
    input  logic              flip,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_q,
    output logic [3:0]        index,
    output logic              opaque,
    output logic              busy,
    output logic              done
);

    localparam int c_FRAME_W = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam int c_TICK_W  = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

    localparam logic [c_FRAME_W-1:0] c_LAST_FRAME = c_FRAME_W'(N_FRAMES - 1);
    localparam logic [c_TICK_W-1:0]  c_LAST_TICK  = c_TICK_W'(TICKS_PER_FRAME - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_PLAY = 1'b1;

    // FSM state and animation counters
    logic [0:0]           r_state;
    logic [0:0]           w_state_next;
    logic [c_FRAME_W-1:0] r_frame;
    logic [c_FRAME_W-1:0] w_frame_next;
    logic [c_TICK_W-1:0]  r_tick_cnt;
    logic [c_TICK_W-1:0]  w_tick_next;
    logic                 r_done;
    logic                 w_done_next;

    // Values latched on frame_tick so a scan never sees them change mid-frame
    logic [9:0]           r_pos_x;
    logic [9:0]           r_pos_y;
    logic                 r_flip;
    logic [c_FRAME_W-1:0] r_frame_l;

    // Pixel pipeline
    logic [10:0]          w_col;
    logic [10:0]          w_row;
    logic                 w_in_box;
    logic [ADDR_W-1:0]    w_addr;
    logic                 r_vis_d1;
    logic                 r_vis_d2;

    // State register: FSM state, frame/tick counters and registered done
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= c_IDLE;
            r_frame    <= '0;
            r_tick_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_frame    <= w_frame_next;
            r_tick_cnt <= w_tick_next;
            r_done     <= w_done_next;
        end
    end

    // Next-state logic: start leaves IDLE (a coincident tick is not counted);
    // in PLAY each frame_tick advances the tick/frame counters
    always_comb begin
        w_state_next = r_state;
        w_frame_next = r_frame;
        w_tick_next  = r_tick_cnt;
        w_done_next  = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_frame_next = '0;
                w_tick_next  = '0;
                if (start) begin
                    w_state_next = c_PLAY;
                end
            end
            c_PLAY: begin
                if (frame_tick) begin
                    if (r_tick_cnt == c_LAST_TICK) begin
                        w_tick_next = '0;
                        if (r_frame == c_LAST_FRAME) begin
                            w_done_next  = 1'b1;
                            w_frame_next = '0;
`ifdef SPRITE_ANIM_LOOP_EN
                            w_state_next = c_PLAY;
`else
                            w_state_next = c_IDLE;
`endif
                        end else begin
                            w_frame_next = r_frame + 1'b1;
                        end
                    end else begin
                        w_tick_next = r_tick_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // Output logic: busy mirrors PLAY, so it drops in the cycle done is high
    always_comb begin
        busy = (r_state == c_PLAY);
        done = r_done;
    end

    // Latch position, mirror and the frame about to be shown on frame_tick.
    // The post-update frame is taken so the new frame appears in the next scan.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pos_x   <= '0;
            r_pos_y   <= '0;
            r_flip    <= 1'b0;
            r_frame_l <= '0;
        end else if (frame_tick) begin
            r_pos_x   <= pos_x;
            r_pos_y   <= pos_y;
            r_flip    <= flip;
            r_frame_l <= w_frame_next;
        end
    end

    // Box test and address: 11-bit signed offsets, a set sign bit means left/above
    // the box; the address is formed at 32 bits and truncated to ADDR_W
    always_comb begin
        w_col    = {1'b0, DrawX} - {1'b0, r_pos_x};
        w_row    = {1'b0, DrawY} - {1'b0, r_pos_y};
        w_in_box = !w_col[10] && (w_col < 11'(SPR_W)) &&
                   !w_row[10] && (w_row < 11'(SPR_H));
        w_addr   = ADDR_W'(32'(r_frame_l) * 32'(SPR_W * SPR_H)
                         + 32'(w_row) * 32'(SPR_W)
                         + (r_flip ? (32'(SPR_W - 1) - 32'(w_col)) : 32'(w_col)));
    end

    // Pixel pipeline: address + visibility, ROM latency, then index/opaque
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr <= '0;
            r_vis_d1 <= 1'b0;
            r_vis_d2 <= 1'b0;
            index    <= 4'h0;
            opaque   <= 1'b0;
        end else begin
            rom_addr <= w_in_box ? w_addr : '0;
            r_vis_d1 <= w_in_box & blank;
            r_vis_d2 <= r_vis_d1;
            index    <= r_vis_d2 ? rom_q : 4'h0;
            opaque   <= r_vis_d2 && (rom_q != 4'h0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_anim_indexer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_anim_indexer
// Description : Self-checking bench for sprite_anim_indexer. Pixel expectations
//               are queued when a scan position is driven and popped when the
//               address (1 clock) and index (3 clocks) emerge. The index ROM is
//               modelled as rom_q = rom_addr[3:0], registered.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_anim_indexer;

`ifdef SPRITE_ANIM_LOOP_EN
    localparam bit c_LOOP = 1'b1;
`else
    localparam bit c_LOOP = 1'b0;
`endif
    localparam int c_FRAME_SZ = 64 * 96;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        blank = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        flip = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic [14:0] rom_addr;
    logic [3:0]  rom_q = '0;
    logic [3:0]  index;
    logic        opaque;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model of the latched sprite state
    int m_px = 0;
    int m_py = 0;
    bit m_flip = 1'b0;
    int m_frame = 0;

    typedef struct {
        int          due;
        logic [14:0] addr;
        logic [3:0]  idx;
        logic        op;
    } exp_t;

    typedef struct {
        int x;
        int y;
        bit vis;
    } pix_t;

    exp_t aq[$];
    exp_t iq[$];

    sprite_anim_indexer #(
        .SPR_W(64), .SPR_H(96), .N_FRAMES(4), .TICKS_PER_FRAME(5), .ADDR_W(15)
    ) dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .frame_tick(frame_tick), .start(start), .flip(flip),
        .pos_x(pos_x), .pos_y(pos_y), .rom_addr(rom_addr), .rom_q(rom_q),
        .index(index), .opaque(opaque), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        rom_q <= rom_addr[3:0];
        cyc   <= cyc + 1;
    end

    function automatic void model_pixel(input int x, input int y, input bit vis,
                                        output logic [14:0] a, output logic [3:0] i,
                                        output logic op);
        int col;
        int row;
        bit inb;
        col = x - m_px;
        row = y - m_py;
        inb = (col >= 0) && (col < 64) && (row >= 0) && (row < 96);
        a   = inb ? 15'(m_frame * c_FRAME_SZ + row * 64 + (m_flip ? 63 - col : col)) : 15'd0;
        i   = (inb && vis) ? a[3:0] : 4'h0;
        op  = (i != 4'h0);
    endfunction

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1; start = 1'b0; frame_tick = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        m_px = 0; m_py = 0; m_flip = 1'b0; m_frame = 0;
    endtask

    // Latch position/flip with a frame_tick while the FSM is idle
    task automatic tick_latch(input int px, input int py, input bit fl);
        @(negedge Clk);
        pos_x = 10'(px); pos_y = 10'(py); flip = fl; frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        m_px = px; m_py = py; m_flip = fl; m_frame = 0;
    endtask

    task automatic pulse_tick();
        @(negedge Clk);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        vectors++; if (rom_addr !== 15'd0) begin miscompares++; $display("FAIL reset rom_addr: got %0d expected 0", rom_addr); end
        vectors++; if (index !== 4'h0) begin miscompares++; $display("FAIL reset index: got %0d expected 0", index); end
        vectors++; if (opaque !== 1'b0) begin miscompares++; $display("FAIL reset opaque: got %b expected 0", opaque); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset done: got %b expected 0", done); end
        // Latched position resets to (0,0): pixel (5,3) lands at 3*64+5
        Reset = 1'b0; DrawX = 10'd5; DrawY = 10'd3; blank = 1'b1;
        @(negedge Clk);
        vectors++; if (rom_addr !== 15'd197) begin miscompares++; $display("FAIL reset pos latch rom_addr: got %0d expected 197", rom_addr); end
        @(negedge Clk);
        @(negedge Clk);
        vectors++; if (index !== 4'd5 || opaque !== 1'b1) begin miscompares++; $display("FAIL reset pos latch index: got %0d/%b expected 5/1", index, opaque); end
        blank = 1'b0;
    endtask

    task automatic test_pixels();
        pix_t stim[$];
        exp_t e;
        logic [14:0] a;
        logic [3:0]  i;
        logic        op;
        do_reset();
        for (int ph = 0; ph < 3; ph++) begin
            stim.delete();
            if (ph == 0) begin
                tick_latch(100, 200, 1'b0);
                for (int x = 100; x < 164; x++) stim.push_back('{x, 200, 1'b1});
                stim.push_back('{99, 200, 1'b1});
                stim.push_back('{164, 200, 1'b1});
                stim.push_back('{120, 296, 1'b1});
                stim.push_back('{120, 295, 1'b1});
                stim.push_back('{110, 200, 1'b0});
                stim.push_back('{100, 199, 1'b1});
            end else if (ph == 1) begin
                tick_latch(100, 200, 1'b1);
                stim.push_back('{100, 201, 1'b1});
                stim.push_back('{163, 201, 1'b1});
                stim.push_back('{130, 250, 1'b1});
                stim.push_back('{100, 201, 1'b0});
            end else begin
                tick_latch(620, 10, 1'b0);
                stim.push_back('{639, 10, 1'b1});
                stim.push_back('{0, 10, 1'b1});
                stim.push_back('{619, 10, 1'b1});
                stim.push_back('{630, 105, 1'b1});
            end
            for (int k = 0; k < stim.size() + 4; k++) begin
                @(negedge Clk);
                while (aq.size() > 0 && aq[0].due <= cyc) begin
                    e = aq.pop_front();
                    vectors++;
                    if (rom_addr !== e.addr) begin
                        miscompares++;
                        $display("FAIL pixel rom_addr ph%0d: got %0d expected %0d", ph, rom_addr, e.addr);
                    end
                end
                while (iq.size() > 0 && iq[0].due <= cyc) begin
                    e = iq.pop_front();
                    vectors++;
                    if (index !== e.idx || opaque !== e.op) begin
                        miscompares++;
                        $display("FAIL pixel index/opaque ph%0d: got %0d/%b expected %0d/%b", ph, index, opaque, e.idx, e.op);
                    end
                end
                if (k < stim.size()) begin
                    DrawX = 10'(stim[k].x); DrawY = 10'(stim[k].y); blank = stim[k].vis;
                    model_pixel(stim[k].x, stim[k].y, stim[k].vis, a, i, op);
                    aq.push_back('{cyc + 1, a, 4'h0, 1'b0});
                    iq.push_back('{cyc + 3, 15'd0, i, op});
                end else begin
                    blank = 1'b0;
                end
            end
            vectors++;
            if (aq.size() != 0 || iq.size() != 0) begin
                miscompares++;
                $display("FAIL pixel scoreboard drain ph%0d: got %0d left expected 0", ph, aq.size() + iq.size());
                aq.delete(); iq.delete();
            end
        end
        flip = 1'b0;
    endtask

    task automatic test_sequence();
        int n;
        do_reset();
        pos_x = 10'd100; pos_y = 10'd200; flip = 1'b0;
        DrawX = 10'd100; DrawY = 10'd200; blank = 1'b1;
        @(negedge Clk); start = 1'b1;
        @(negedge Clk); start = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL seq busy rise: got %b expected 1", busy); end
        n = c_LOOP ? 40 : 20;
        for (int t = 1; t <= n; t++) begin
            pulse_tick();
            vectors++;
            if (done !== (t % 20 == 0)) begin miscompares++; $display("FAIL seq done tick %0d: got %b expected %b", t, done, (t % 20 == 0)); end
            vectors++;
            if (busy !== (c_LOOP || t < 20)) begin miscompares++; $display("FAIL seq busy tick %0d: got %b expected %b", t, busy, (c_LOOP || t < 20)); end
            @(negedge Clk);
            vectors++;
            if (done !== 1'b0) begin miscompares++; $display("FAIL seq done width tick %0d: got %b expected 0", t, done); end
            vectors++;
            if (rom_addr !== 15'(((t % 20) / 5) * c_FRAME_SZ)) begin
                miscompares++;
                $display("FAIL seq frame addr tick %0d: got %0d expected %0d", t, rom_addr, ((t % 20) / 5) * c_FRAME_SZ);
            end
        end
    endtask

    task automatic test_start_coincident();
        do_reset();
        pos_x = 10'd100; pos_y = 10'd200; flip = 1'b0;
        DrawX = 10'd100; DrawY = 10'd200; blank = 1'b1;
        @(negedge Clk); start = 1'b1; frame_tick = 1'b1;
        @(negedge Clk); start = 1'b0; frame_tick = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL coincident busy: got %b expected 1", busy); end
        for (int t = 1; t <= 5; t++) begin
            pulse_tick();
            @(negedge Clk);
            vectors++;
            if (rom_addr !== 15'((t / 5) * c_FRAME_SZ)) begin
                miscompares++;
                $display("FAIL coincident frame addr tick %0d: got %0d expected %0d", t, rom_addr, (t / 5) * c_FRAME_SZ);
            end
        end
    endtask

    task automatic test_start_in_play();
        do_reset();
        pos_x = 10'd100; pos_y = 10'd200; flip = 1'b0;
        DrawX = 10'd100; DrawY = 10'd200; blank = 1'b1;
        @(negedge Clk); start = 1'b1;
        @(negedge Clk); start = 1'b0;
        for (int t = 1; t <= 3; t++) pulse_tick();
        @(negedge Clk); start = 1'b1;
        @(negedge Clk); start = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL start in play busy: got %b expected 1", busy); end
        for (int t = 4; t <= 20; t++) begin
            pulse_tick();
            vectors++;
            if (done !== (t == 20)) begin miscompares++; $display("FAIL start in play done tick %0d: got %b expected %b", t, done, (t == 20)); end
        end
        @(negedge Clk);
        vectors++; if (busy !== c_LOOP) begin miscompares++; $display("FAIL start in play busy end: got %b expected %b", busy, c_LOOP); end
    endtask

    task automatic test_reset_mid_play();
        do_reset();
        pos_x = 10'd100; pos_y = 10'd200; flip = 1'b0;
        DrawX = 10'd100; DrawY = 10'd200; blank = 1'b1;
        @(negedge Clk); start = 1'b1;
        @(negedge Clk); start = 1'b0;
        for (int t = 1; t <= 7; t++) pulse_tick();
        @(negedge Clk); Reset = 1'b1;
        @(negedge Clk); Reset = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid reset busy: got %b expected 0", busy); end
        vectors++; if (rom_addr !== 15'd0 || index !== 4'h0 || opaque !== 1'b0) begin
            miscompares++; $display("FAIL mid reset pipeline: got %0d/%0d/%b expected 0/0/0", rom_addr, index, opaque);
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (done !== 1'b0) begin miscompares++; $display("FAIL mid reset done cycle %0d: got %b expected 0", k, done); end
            @(negedge Clk);
        end
        DrawX = 10'd105;
        pulse_tick();
        @(negedge Clk);
        vectors++; if (rom_addr !== 15'd5) begin miscompares++; $display("FAIL mid reset frame0 addr: got %0d expected 5", rom_addr); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid reset idle tick busy: got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_pixels();
        test_sequence();
        test_start_coincident();
        test_start_in_play();
        test_reset_mid_play();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule
`default_nettype wire
